// File: rtl/data_mem_ctrl.sv
// Data memory controller: latency-configurable single-port word array
// with byte/half/word writes. Define DMEM_ALIGN_CHECK_EN to add dmem_misalign.
module data_mem_ctrl #(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dmem_addr,
    input  logic        dmem_r_enable,
    input  logic        dmem_w_enable,
    input  logic [1:0]  dmem_w_size,
    input  logic [31:0] dmem_w_data,
    output logic [31:0] dmem_r_data,
    output logic        dmem_ready
`ifdef DMEM_ALIGN_CHECK_EN
    ,
    output logic        dmem_misalign
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY > 1 ? LATENCY - 2 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic [AW+1:0] addr_q;
    logic [1:0]    size_q;
    logic [31:0]   wdata_q;
    logic          we_q;

    logic [31:0]   mem [DEPTH];

    logic          accept;
    logic          enter_resp;
    logic [AW-1:0] sel_idx;
    logic [3:0]    be;
    logic [31:0]   wd;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^dmem_addr[31:AW+2];

    assign accept = (state == IDLE) && (dmem_r_enable || dmem_w_enable);

    // RESP is entered straight from IDLE only for single-cycle latency
    assign enter_resp = (accept && (LATENCY == 1)) ||
                        ((state == WAIT) && (cnt == 4'd0));

    // On the accepting edge the latches are not loaded yet, so look at the inputs
    assign sel_idx = (state == IDLE) ? dmem_addr[AW+1:2] : addr_q[AW+1:2];

    function automatic logic misal(input logic [1:0] sz, input logic [1:0] a);
        return ((sz == 2'b01) && a[0]) || (sz[1] && (a != 2'b00));
    endfunction

`ifdef DMEM_ALIGN_CHECK_EN
    logic sel_mis;
    assign sel_mis = (state == IDLE)
        ? (dmem_w_enable && misal(dmem_w_size, dmem_addr[1:0]))
        : (we_q && misal(size_q, addr_q[1:0]));
`endif

    // Lane enables and lane-replicated write data from the latched request
    always_comb begin
        be = 4'b0000;
        wd = 32'd0;
        case (size_q)
            2'b00: begin
                be = 4'b0001 << addr_q[1:0];
                wd = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be = addr_q[1] ? 4'b1100 : 4'b0011;
                wd = {2{wdata_q[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = wdata_q;
            end
        endcase
`ifdef DMEM_ALIGN_CHECK_EN
        if (misal(size_q, addr_q[1:0])) be = 4'b0000;
`endif
    end

    // Request FSM with registered ready/data (pre-write word is sampled)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            addr_q      <= '0;
            size_q      <= 2'b00;
            wdata_q     <= 32'd0;
            we_q        <= 1'b0;
            dmem_ready  <= 1'b0;
            dmem_r_data <= 32'd0;
`ifdef DMEM_ALIGN_CHECK_EN
            dmem_misalign <= 1'b0;
`endif
        end else begin
            dmem_ready  <= enter_resp;
            dmem_r_data <= enter_resp ? mem[sel_idx] : 32'd0;
`ifdef DMEM_ALIGN_CHECK_EN
            dmem_misalign <= enter_resp && sel_mis;
`endif
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q  <= dmem_addr[AW+1:0];
                        size_q  <= dmem_w_size;
                        wdata_q <= dmem_w_data;
                        we_q    <= dmem_w_enable;
                        cnt     <= CNT_INIT;
                        state   <= (LATENCY > 1) ? WAIT : RESP;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) state <= RESP;
                    else cnt <= cnt - 4'd1;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Array write commits on the edge leaving RESP; never during reset
    always_ff @(posedge clk) begin
        if ((state == RESP) && we_q && !reset) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr_q[AW+1:2]][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter LATENCY, default 2: cycles from request acceptance to ready; legal range 1..15.
REQ-002 Parameter DEPTH, default 1024: array size in 32-bit words; power of two.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port dmem_addr  input  32  byte address of the request.
REQ-006 Port dmem_r_enable  input  1  read request.
REQ-007 Port dmem_w_enable  input  1  write request.
REQ-008 Port dmem_w_size  input  2  write size: 00 byte, 01 half, 10 word, 11 treated as word.
REQ-009 Port dmem_w_data  input  32  write data, right-justified (byte in [7:0], half in [15:0]).
REQ-010 Port dmem_r_data  output  32  aligned word at dmem_addr[31:2]; valid only while dmem_ready=1.
REQ-011 Port dmem_ready  output  1  one-cycle completion strobe for the accepted request.

Function
REQ-012 The FSM SHALL have states IDLE, WAIT and RESP; reset state is IDLE.
REQ-013 In IDLE with dmem_r_enable|dmem_w_enable=1, the block SHALL latch addr, size, wdata and type, then go to WAIT (LATENCY>1) or RESP (LATENCY=1).
REQ-014 WAIT SHALL hold a 4-bit down-counter loaded with LATENCY-2 and go to RESP when it reaches 0.
REQ-015 Ready timing: a request accepted at edge N SHALL see dmem_ready=1 for exactly one cycle, the cycle following edge N+LATENCY-1.
REQ-016 RESP SHALL assert dmem_ready and drive dmem_r_data, then go to IDLE unconditionally.
REQ-017 dmem_ready SHALL be 0 in IDLE and WAIT.
REQ-018 Enables still high in the IDLE cycle after RESP SHALL be accepted as a new request.
REQ-019 Request inputs SHALL be ignored in WAIT and RESP; the latched request completes even if the enables drop.
REQ-020 Writes SHALL commit to the array at the RESP edge, with byte lanes selected by size and latched addr[1:0]: byte to lane addr[1:0], half to lanes {addr[1],0}+1..0, word to all four lanes.
REQ-021 If both enables are high at acceptance, the block SHALL perform the write, and dmem_r_data SHALL return the pre-write word.
REQ-022 The word index SHALL be addr[31:2] modulo DEPTH, so out-of-range addresses wrap.
REQ-023 dmem_r_data SHALL be 0 whenever dmem_ready=0.

Reset
REQ-024 While reset is asserted, the block SHALL hold the FSM in IDLE, the counter at 0, dmem_ready at 0 and dmem_r_data at 0, independent of clk.
REQ-025 Reset asserted during WAIT or RESP SHALL abort the request with no array write committed.
REQ-026 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-027 Macro DMEM_ALIGN_CHECK_EN, when defined, SHALL add output dmem_misalign (1 bit, reset 0), asserted together with dmem_ready for a half access with addr[0]=1 or a word access with addr[1:0]!=0; a misaligned write SHALL NOT modify the array.
REQ-028 Without DMEM_ALIGN_CHECK_EN, the block SHALL have no dmem_misalign port; a misaligned half SHALL be forced to lanes {addr[1],0}, and a misaligned word SHALL use addr[1:0]=00.

Verification
REQ-029 The bench SHALL check: LATENCY=2, write word 0xDEADBEEF at 0x10, then read 0x10 -> ready exactly 2 cycles after each acceptance, and read data 0xDEADBEEF.
REQ-030 The bench SHALL check: byte write 0xAA at 0x13 over word 0x11223344 -> read 0x10 returns 0xAA223344.
REQ-031 The bench SHALL check: LATENCY=1 with back-to-back held reads of 0x0 and 0x4 -> ready every other cycle, with correct data each time.
REQ-032 The bench SHALL check: reset pulsed during WAIT of a write to 0x20 -> ready never asserts, and word 0x20 keeps its prior value.
REQ-033 The bench SHALL check: DEPTH=1024, write 0x5 to address 0x1000 -> read 0x0 returns 0x5.
REQ-034 The bench SHALL check: with DMEM_ALIGN_CHECK_EN defined, word write to 0x22 -> dmem_misalign=1 together with ready, and word 0x20 is unchanged.
